// File: rtl/psram_fb_arbiter.sv
// Arbitrates one PSRAM port between front-bank scanout reads and FIFO-buffered back-bank writes; FB_CLEAR_EN adds a back-bank fill engine.
// Latency: rd_req to rd_valid is 4 cycles plus controller busy time when the arbiter is idle.
// Backpressure: wr_ready drops while the write FIFO is full or a clear runs; reads never stall, a second rd_req overwrites and flags rd_overrun.
module psram_fb_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_WORDS   = 86_400
) (
    input  logic        clk_mem,
    input  logic        reset_n,
`ifdef FB_CLEAR_EN
    input  logic        clear_start,
    input  logic [15:0] clear_data,
    output logic        clear_busy,
`endif
    input  logic [19:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [19:0] rd_addr,
    input  logic        rd_req,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        rd_overrun,
    input  logic        vblank,
    input  logic        flip_req,
    output logic        flip_pending,
    output logic        render_bank,
    output logic [21:0] mem_addr,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (FB_WORDS < 1 || FB_WORDS > (1 << 20)) begin : g_bad_words
        $error("FB_WORDS must lie in 1..2^20");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_t;
    typedef enum logic [1:0] {K_RD, K_WR, K_CLR} kind_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_ent_t;

    state_t      state, state_nxt;
    kind_t       cmd_kind, sel_kind;
    logic [21:0] cmd_addr, sel_addr;
    logic [15:0] cmd_data, sel_data;
    logic        issue;
    logic        do_flip;
    logic        ready_en;

    logic        rd_pend;
    logic [19:0] rd_addr_q;
    logic        rd_issue;

    wr_ent_t     fifo_mem [FIFO_DEPTH];
    wr_ent_t     fifo_head;
    logic [AW-1:0] fifo_wptr, fifo_rptr;
    logic [AW:0] fifo_cnt;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic        clearing;
    logic [15:0] clr_data_q;
    logic [19:0] clr_addr;

    // ---------------- write FIFO ----------------
    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_head  = fifo_mem[fifo_rptr];
    assign wr_ready   = ready_en && !fifo_full && !clearing;
    assign fifo_push  = wr_valid && wr_ready;
    assign fifo_pop   = (state == S_ISSUE) && (cmd_kind == K_WR);

    always_ff @(posedge clk_mem) begin
        if (fifo_push) begin
            fifo_mem[fifo_wptr] <= '{addr: wr_addr, data: wr_data};
        end
    end

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            fifo_wptr <= '0;
            fifo_rptr <= '0;
            fifo_cnt  <= '0;
        end else begin
            if (fifo_push) fifo_wptr <= fifo_wptr + 1'b1;
            if (fifo_pop)  fifo_rptr <= fifo_rptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Holds wr_ready low through reset so every output reads 0 there.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    // ---------------- read request latch ----------------
    assign rd_issue = (state == S_ISSUE) && (cmd_kind == K_RD);

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend    <= 1'b0;
            rd_addr_q  <= '0;
            rd_overrun <= 1'b0;
        end else if (rd_req) begin
            rd_pend   <= 1'b1;
            rd_addr_q <= rd_addr;
            if (rd_pend && !rd_issue) rd_overrun <= 1'b1;
        end else if (rd_issue) begin
            rd_pend <= 1'b0;
        end
    end

    // ---------------- clear engine ----------------
`ifdef FB_CLEAR_EN
    localparam logic [19:0] CLR_LAST = 20'(FB_WORDS - 1);
    logic clr_accept, clr_step;

    assign clr_accept = clear_start && (state == S_IDLE) && fifo_empty && !clearing;
    assign clr_step   = (state == S_WAIT) && !mem_busy && (cmd_kind == K_CLR);
    assign clear_busy = clearing;

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            clearing   <= 1'b0;
            clr_data_q <= '0;
            clr_addr   <= '0;
        end else if (clr_accept) begin
            clearing   <= 1'b1;
            clr_data_q <= clear_data;
            clr_addr   <= '0;
        end else if (clr_step) begin
            if (clr_addr == CLR_LAST) clearing <= 1'b0;
            else                      clr_addr <= clr_addr + 1'b1;
        end
    end
`else
    assign clearing   = 1'b0;
    assign clr_data_q = '0;
    assign clr_addr   = '0;
`endif

    // ---------------- transfer FSM ----------------
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        do_flip   = 1'b0;
        sel_kind  = K_RD;
        sel_addr  = '0;
        sel_data  = '0;
        case (state)
            S_IDLE: begin
                if (!mem_busy && rd_pend) begin
                    issue    = 1'b1;
                    sel_kind = K_RD;
                    sel_addr = {render_bank, 1'b0, rd_addr_q};
                end else if (!mem_busy && clearing) begin
                    issue    = 1'b1;
                    sel_kind = K_CLR;
                    sel_addr = {~render_bank, 1'b0, clr_addr};
                    sel_data = clr_data_q;
                end else if (!mem_busy && !fifo_empty) begin
                    issue    = 1'b1;
                    sel_kind = K_WR;
                    sel_addr = {~render_bank, 1'b0, fifo_head.addr};
                    sel_data = fifo_head.data;
                end else if (flip_pending && vblank && fifo_empty && !clearing && !rd_pend) begin
                    do_flip = 1'b1;
                end
                if (issue) state_nxt = S_ISSUE;
            end
            S_ISSUE: state_nxt = S_GUARD;
            // The controller may raise busy one cycle late, so busy is not trusted here.
            S_GUARD: state_nxt = S_WAIT;
            S_WAIT:  if (!mem_busy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bank is frozen into cmd_addr here; flips only happen in IDLE with nothing selected.
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            cmd_kind <= K_RD;
            cmd_addr <= '0;
            cmd_data <= '0;
        end else if (issue) begin
            cmd_kind <= sel_kind;
            cmd_addr <= sel_addr;
            cmd_data <= sel_data;
        end
    end

    assign mem_read_en  = (state == S_ISSUE) && (cmd_kind == K_RD);
    assign mem_write_en = (state == S_ISSUE) && (cmd_kind != K_RD);
    assign mem_addr     = cmd_addr;
    assign mem_wdata    = cmd_data;

    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if ((state == S_WAIT) && !mem_busy && (cmd_kind == K_RD)) begin
                rd_valid <= 1'b1;
                rd_data  <= mem_rdata;
            end
        end
    end

    // ---------------- bank flip ----------------
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            render_bank  <= 1'b0;
            flip_pending <= 1'b0;
        end else if (do_flip) begin
            render_bank  <= ~render_bank;
            flip_pending <= 1'b0;
        end else if (flip_req) begin
            flip_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psram_fb_arbiter.sv
// Directed bench for psram_fb_arbiter: PSRAM controller model with 3 busy cycles lagging each command by one cycle.
// Read data model: mem_rdata = mem_addr[15:0] ^ 16'h5A5A.
module tb_psram_fb_arbiter;

    localparam int BUSY_LEN = 3;

    logic        clk_mem = 1'b0;
    logic        reset_n;
`ifdef FB_CLEAR_EN
    logic        clear_start;
    logic [15:0] clear_data;
    logic        clear_busy;
`endif
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [19:0] rd_addr;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_overrun;
    logic        vblank;
    logic        flip_req;
    logic        flip_pending;
    logic        render_bank;
    logic [21:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_busy;

    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    logic        busy_hold = 1'b0;
    int          rdv_cnt = 0;
    logic [15:0] rdv_data = 16'h0000;
    logic        log_rd [$];
    logic [21:0] log_addr [$];
    logic [15:0] log_data [$];

    always #5 clk_mem = ~clk_mem;

    assign mem_busy = busy_hold || (busy_cnt >= 1 && busy_cnt <= BUSY_LEN);

    psram_fb_arbiter #(.FIFO_DEPTH(8), .FB_WORDS(16)) dut (
        .clk_mem      (clk_mem),
        .reset_n      (reset_n),
`ifdef FB_CLEAR_EN
        .clear_start  (clear_start),
        .clear_data   (clear_data),
        .clear_busy   (clear_busy),
`endif
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_addr      (rd_addr),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_overrun   (rd_overrun),
        .vblank       (vblank),
        .flip_req     (flip_req),
        .flip_pending (flip_pending),
        .render_bank  (render_bank),
        .mem_addr     (mem_addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_busy     (mem_busy)
    );

    // Controller model and command / read-result monitors.
    always @(posedge clk_mem) begin
        if (mem_read_en === 1'b1 || mem_write_en === 1'b1) begin
            busy_cnt <= BUSY_LEN + 1;
            log_rd.push_back(mem_read_en);
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (mem_read_en === 1'b1) mem_rdata <= mem_addr[15:0] ^ 16'h5A5A;
        if (rd_valid === 1'b1) begin
            rdv_cnt  <= rdv_cnt + 1;
            rdv_data <= rd_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        int rv;

        reset_n  = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_valid = 1'b0;
        rd_addr  = '0;
        rd_req   = 1'b0;
        vblank   = 1'b0;
        flip_req = 1'b0;
`ifdef FB_CLEAR_EN
        clear_start = 1'b0;
        clear_data  = '0;
`endif
        repeat (2) @(negedge clk_mem);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_overrun", rd_overrun, 0);
        chk("rst_flip_pending", flip_pending, 0);
        chk("rst_render_bank", render_bank, 0);
        chk("rst_mem_en", {mem_read_en, mem_write_en}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_mem);
        chk("idle_wr_ready", wr_ready, 1);

        // Single read from idle
        rd_addr = 20'h00010;
        rd_req  = 1'b1;
        @(negedge clk_mem);
        rd_req = 1'b0;
        @(negedge clk_mem);
        chk("t1_read_en", mem_read_en, 1);
        chk("t1_mem_addr", mem_addr, 32'h000010);
        n = 2;
        while (rd_valid !== 1'b1 && n < 20) begin
            @(negedge clk_mem);
            n++;
        end
        chk("t1_latency", n, 8);
        chk("t1_rd_data", rd_data, 32'h5A4A);
        @(negedge clk_mem);
        chk("t1_rd_valid_pulse", rd_valid, 0);

        // Fill the FIFO while the controller is held busy
        busy_hold = 1'b1;
        base = log_addr.size();
        for (int i = 0; i < 8; i++) begin
            wr_addr  = 20'h00100 + 20'(i);
            wr_data  = 16'h1000 + 16'(i);
            wr_valid = 1'b1;
            @(negedge clk_mem);
        end
        chk("t2_full_ready", wr_ready, 0);
        wr_addr = 20'h001FF;
        wr_data = 16'hDEAD;
        @(negedge clk_mem);
        wr_valid = 1'b0;
        chk("t2_still_full", wr_ready, 0);
        chk("t2_no_cmd_while_busy", log_addr.size() - base, 0);
        busy_hold = 1'b0;
        n = 0;
        while (log_addr.size() < base + 8 && n < 300) begin
            @(negedge clk_mem);
            n++;
        end
        repeat (12) @(negedge clk_mem);
        chk("t2_write_count", log_addr.size() - base, 8);
        for (int i = 0; i < 8 && base + i < log_addr.size(); i++) begin
            chk("t2_wr_addr", {log_rd[base+i], log_addr[base+i]}, 32'h200100 + 32'(i));
            chk("t2_wr_data", log_data[base+i], 32'h1000 + 32'(i));
        end
        chk("t2_ready_after_drain", wr_ready, 1);

        // Read overtakes queued writes
        busy_hold = 1'b1;
        base = log_addr.size();
        for (int i = 0; i < 3; i++) begin
            wr_addr  = 20'h00300 + 20'(i);
            wr_data  = 16'h3000 + 16'(i);
            wr_valid = 1'b1;
            @(negedge clk_mem);
        end
        wr_valid  = 1'b0;
        busy_hold = 1'b0;
        n = 0;
        while (mem_write_en !== 1'b1 && n < 20) begin
            @(negedge clk_mem);
            n++;
        end
        chk("t3_first_write_seen", mem_write_en, 1);
        repeat (2) @(negedge clk_mem);
        rv      = rdv_cnt;
        rd_addr = 20'h0ABCD;
        rd_req  = 1'b1;
        @(negedge clk_mem);
        rd_req = 1'b0;
        n = 0;
        while (log_addr.size() < base + 4 && n < 200) begin
            @(negedge clk_mem);
            n++;
        end
        repeat (10) @(negedge clk_mem);
        chk("t3_cmd_count", log_addr.size() - base, 4);
        if (log_addr.size() >= base + 4) begin
            chk("t3_cmd0", {log_rd[base], log_addr[base]}, 32'h200300);
            chk("t3_cmd1_read", {log_rd[base+1], log_addr[base+1]}, 32'h40ABCD);
            chk("t3_cmd2", {log_rd[base+2], log_addr[base+2]}, 32'h200301);
            chk("t3_cmd3", {log_rd[base+3], log_addr[base+3]}, 32'h200302);
        end
        chk("t3_rd_count", rdv_cnt - rv, 1);
        chk("t3_rd_data", rdv_data, 32'hF197);

        // Flip deferred until the FIFO drains; repeat request absorbed
        busy_hold = 1'b1;
        base = log_addr.size();
        for (int i = 0; i < 3; i++) begin
            wr_addr  = 20'h00400 + 20'(i);
            wr_data  = 16'h4000 + 16'(i);
            wr_valid = 1'b1;
            @(negedge clk_mem);
        end
        wr_valid = 1'b0;
        vblank   = 1'b1;
        flip_req = 1'b1;
        @(negedge clk_mem);
        flip_req = 1'b0;
        @(negedge clk_mem);
        chk("t4_flip_pending", flip_pending, 1);
        chk("t4_bank_held", render_bank, 0);
        busy_hold = 1'b0;
        n = 0;
        while (mem_write_en !== 1'b1 && n < 20) begin
            @(negedge clk_mem);
            n++;
        end
        flip_req = 1'b1;
        @(negedge clk_mem);
        flip_req = 1'b0;
        n = 0;
        while (render_bank !== 1'b1 && n < 200) begin
            @(negedge clk_mem);
            n++;
        end
        chk("t4_bank_toggled", render_bank, 1);
        chk("t4_writes_before_flip", log_addr.size() - base, 3);
        chk("t4_pending_cleared", flip_pending, 0);
        if (log_addr.size() >= base + 3) begin
            chk("t4_last_write_bank", {log_rd[base+2], log_addr[base+2]}, 32'h200402);
        end
        repeat (15) @(negedge clk_mem);
        chk("t4_single_toggle", render_bank, 1);
        chk("t4_no_new_pending", flip_pending, 0);
        vblank = 1'b0;

        // Overrun: second request replaces the first
        busy_hold = 1'b1;
        base = log_addr.size();
        rv   = rdv_cnt;
        rd_addr = 20'h00555;
        rd_req  = 1'b1;
        @(negedge clk_mem);
        rd_req = 1'b0;
        chk("t5_no_overrun_yet", rd_overrun, 0);
        @(negedge clk_mem);
        rd_addr = 20'h00777;
        rd_req  = 1'b1;
        @(negedge clk_mem);
        rd_req = 1'b0;
        chk("t5_overrun", rd_overrun, 1);
        busy_hold = 1'b0;
        n = 0;
        while (rdv_cnt == rv && n < 50) begin
            @(negedge clk_mem);
            n++;
        end
        repeat (10) @(negedge clk_mem);
        chk("t5_one_cmd", log_addr.size() - base, 1);
        if (log_addr.size() > base) begin
            chk("t5_read_addr", {log_rd[base], log_addr[base]}, 32'h600777);
        end
        chk("t5_rd_count", rdv_cnt - rv, 1);
        chk("t5_rd_data", rdv_data, 32'h5D2D);
        chk("t5_overrun_sticky", rd_overrun, 1);

        // Reset mid-read abandons the transfer
        rv = rdv_cnt;
        rd_addr = 20'h00123;
        rd_req  = 1'b1;
        @(negedge clk_mem);
        rd_req = 1'b0;
        n = 0;
        while (mem_read_en !== 1'b1 && n < 20) begin
            @(negedge clk_mem);
            n++;
        end
        repeat (2) @(negedge clk_mem);
        reset_n = 1'b0;
        @(negedge clk_mem);
        chk("t6_rst_bank", render_bank, 0);
        chk("t6_rst_overrun", rd_overrun, 0);
        chk("t6_rst_ready", wr_ready, 0);
        reset_n = 1'b1;
        repeat (12) @(negedge clk_mem);
        chk("t6_no_rd_valid", rdv_cnt - rv, 0);
        chk("t6_ready_back", wr_ready, 1);

`ifdef FB_CLEAR_EN
        // Clear engine fills the back bank
        base = log_addr.size();
        clear_data  = 16'hF800;
        clear_start = 1'b1;
        @(negedge clk_mem);
        clear_start = 1'b0;
        clear_data  = 16'h0000;
        chk("t7_clear_busy", clear_busy, 1);
        chk("t7_ready_low", wr_ready, 0);
        n = 0;
        while (clear_busy !== 1'b0 && n < 400) begin
            @(negedge clk_mem);
            n++;
        end
        repeat (3) @(negedge clk_mem);
        chk("t7_clear_done", clear_busy, 0);
        chk("t7_word_count", log_addr.size() - base, 16);
        for (int i = 0; i < 16 && base + i < log_addr.size(); i++) begin
            chk("t7_clr_addr", {log_rd[base+i], log_addr[base+i]}, 32'h200000 + 32'(i));
            chk("t7_clr_data", log_data[base+i], 32'hF800);
        end
        chk("t7_ready_after", wr_ready, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
